hart_mem_arbiter: RTL and testbench
===================================

Name: hart_mem_arbiter

Overview:
- Shares one single-port memory between the hart's instruction port (imem) and data port (dmem).
- Produces the hart's imem_stall/dmem_stall.
- Holds exactly one memory transaction outstanding at a time.
- Sits between the riscv Hart and the SoC memory/bus bridge, so a unified RAM can back both ports.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data width; fixed at 32, and wmask is DATA_W/8 bits wide.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  in  1  fetch request; held until imem_stall=0
- imem_addr  in  ADDR_W  fetch address
- imem_data  out  DATA_W  fetch data; valid when imem_req=1 and imem_stall=0
- imem_stall  out  1  fetch not complete
- dmem_req  in  1  load/store request; held until dmem_stall=0
- dmem_addr  in  ADDR_W  data address
- dmem_wmask  in  4  byte write mask; 0 means read
- dmem_wdata  in  DATA_W  store data
- dmem_rdata  out  DATA_W  load data; valid when dmem_req=1 and dmem_stall=0
- dmem_stall  out  1  data access not complete
- mem_valid  out  1  memory request
- mem_addr  out  ADDR_W  word address, low 2 bits forced to 0
- mem_wmask  out  4  byte write mask; 0 means read
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts and completes the request this cycle
- mem_rdata  in  DATA_W  read data, valid in the mem_ready cycle

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous assert, synchronous deassert (external synchroniser).
- Reset values: state=IDLE; mem_valid=0; mem_addr/mem_wmask/mem_wdata=0; last_grant=IMEM.
- States: IDLE, IBUSY, DBUSY.
- IDLE:
  - Only dmem_req -> DBUSY.
  - Only imem_req -> IBUSY.
  - Both -> the pick rule decides.
  - On the transition, register addr/wmask/wdata from the chosen port and set mem_valid=1 next cycle.
  - imem requests always register wmask=0 and wdata=0.
- IBUSY/DBUSY:
  - mem_valid=1; mem_addr/wmask/wdata are registered and stable.
  - Stay in the state while mem_ready=0.
  - On mem_ready=1: complete the transaction, go to IDLE, clear mem_valid, and update last_grant.
- Stall outputs (combinational):
  - imem_stall = imem_req and not (state==IBUSY and mem_ready).
  - dmem_stall is defined likewise for DBUSY.
  - A port with req=0 sees stall=0.
- Data outputs: imem_data and dmem_rdata pass mem_rdata through combinationally. Outside the owning port's completion cycle they are don't-care; drive mem_rdata on both.
- Latency:
  - Request in cycle N (from IDLE) -> mem_valid in N+1.
  - With zero-wait memory, stall drops in N+1.
  - The arbiter is back in IDLE at N+2, so peak throughput is one access per 2 cycles.
- Simultaneous requests: the loser stays stalled and is granted from IDLE after the winner completes. There is no direct BUSY->BUSY transition.
- Request withdrawal: if req drops while the arbiter is busy for that port, this is a protocol violation. The transaction still completes to memory and the result is discarded. An assertion flags it.
- Stores: write-only. dmem_rdata content for a store is don't-care, but dmem_stall must still drop in the completion cycle.
- Reset mid-transaction:
  - Immediately forces IDLE and mem_valid=0.
  - The memory must share the reset; no completion is reported.

Optional Feature:
HART_MEM_ARB_RR_EN
- Defined: on simultaneous requests in IDLE, grant the port that was not last_grant (round-robin), so neither port can be starved.
- Undefined: fixed priority, dmem always wins. Rationale: the data access belongs to the older instruction. The last_grant flop is removed.

Decomposition:
- Package hart_mem_pkg:
  - arb_state_t enum {IDLE, IBUSY, DBUSY}
  - port_sel_t enum {SEL_IMEM, SEL_DMEM}
  - WMASK_W=4 constant
- Sub-module hart_mem_arb_pick, combinational:
  - Inputs: imem_req, dmem_req, last_grant.
  - Outputs: grant_valid, grant_sel.
  - Contains the ifdef'd priority logic, so the FSM stays identical in both builds.

Test Plan:
1. imem_req=1, addr 0x0000_0103, mem_ready tied 1, mem_rdata=0x0000_0013 -> mem_addr=0x100 and mem_wmask=0 in cycle 1; imem_stall=0 and imem_data=0x13 in cycle 1; state back to IDLE in cycle 2.
2. dmem store: addr 0x2000, wmask 0b0011, wdata 0xDEAD_BEEF, mem_ready delayed 3 cycles -> mem_valid high for 4 cycles with stable fields; dmem_stall=1 for 3 cycles then 0.
3. Both requests in the same cycle, fixed-priority build -> dmem served first, imem served next; imem_stall=1 for 3 cycles with zero-wait memory.
4. Same as 3 but repeated with dmem_req held continuously and HART_MEM_ARB_RR_EN defined -> grants alternate D, I, D, I; without the macro, imem never completes within 20 cycles.
5. Assert rst_n=0 mid-DBUSY with mem_ready=0 -> mem_valid=0 asynchronously; after release the state is IDLE, and a new imem_req completes normally.
6. Random stall/ready stimulus with a scoreboard -> every request completes exactly once, in grant order, with fields stable while mem_valid=1 and mem_ready=0.

Source files
------------

// File: rtl/hart_mem_pkg.sv
// Shared types for the hart instruction/data memory arbiter.
// Optional round-robin arbitration is enabled with HART_MEM_ARB_RR_EN.
package hart_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEL_IMEM = 1'b0,
    SEL_DMEM = 1'b1
  } port_sel_t;

  localparam int WMASK_W = 4;

endpackage

// File: rtl/hart_mem_arb_pick.sv
// Grant selection between the fetch and load/store ports.
// HART_MEM_ARB_RR_EN selects round-robin; otherwise dmem has fixed priority.
module hart_mem_arb_pick
  import hart_mem_pkg::*;
(
  input  logic      imem_req,
  input  logic      dmem_req,
  input  port_sel_t last_grant,
  output logic      grant_valid,
  output port_sel_t grant_sel
);

  assign grant_valid = imem_req | dmem_req;

  always_comb begin
    grant_sel = SEL_IMEM;
    if (imem_req && dmem_req) begin
`ifdef HART_MEM_ARB_RR_EN
      // Contested cycle: the port served least recently goes first.
      grant_sel = (last_grant == SEL_IMEM) ? SEL_DMEM : SEL_IMEM;
`else
      // The data access belongs to the older instruction in the pipeline.
      grant_sel = SEL_DMEM;
`endif
    end else if (dmem_req) begin
      grant_sel = SEL_DMEM;
    end
  end

`ifndef HART_MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares one single-port memory between the hart imem and dmem ports, one access in flight.
// Build option HART_MEM_ARB_RR_EN: round-robin grant on simultaneous requests.
module hart_mem_arbiter
  import hart_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_req,
  input  logic [ADDR_W-1:0]  imem_addr,
  output logic [DATA_W-1:0]  imem_data,
  output logic               imem_stall,
  input  logic               dmem_req,
  input  logic [ADDR_W-1:0]  dmem_addr,
  input  logic [WMASK_W-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]  dmem_wdata,
  output logic [DATA_W-1:0]  dmem_rdata,
  output logic               dmem_stall,
  output logic               mem_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WMASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata,
  output arb_state_t         dbg_state
);

  // Memory handshake: mem_valid rises the cycle after a grant and holds with
  // stable addr/wmask/wdata until the cycle mem_ready=1, which completes the
  // access; the hart ports see stall=0 exactly in that completion cycle.

  arb_state_t state_q;
  arb_state_t state_d;
  port_sel_t  last_grant;
  logic       grant_valid;
  port_sel_t  grant_sel;
  logic       load;

  hart_mem_arb_pick u_pick (
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = (grant_sel == SEL_DMEM) ? DBUSY : IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        // Always return through IDLE so the loser is re-arbitrated there.
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        if (grant_sel == SEL_DMEM) begin
          mem_addr  <= {dmem_addr[ADDR_W-1:2], 2'b00};
          mem_wmask <= dmem_wmask;
          mem_wdata <= dmem_wdata;
        end else begin
          mem_addr  <= {imem_addr[ADDR_W-1:2], 2'b00};
          mem_wmask <= '0;
          mem_wdata <= '0;
        end
      end
    end
  end

`ifdef HART_MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SEL_IMEM;
    end else if ((state_q != IDLE) && mem_ready) begin
      last_grant <= (state_q == DBUSY) ? SEL_DMEM : SEL_IMEM;
    end
  end
`else
  assign last_grant = SEL_IMEM;
`endif

  assign mem_valid  = (state_q != IDLE);
  assign imem_stall = imem_req & ~((state_q == IBUSY) & mem_ready);
  assign dmem_stall = dmem_req & ~((state_q == DBUSY) & mem_ready);
  assign imem_data  = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign dbg_state  = state_q;

  // Byte offsets are dropped: the memory is word addressed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{imem_addr[1:0], dmem_addr[1:0]};

  // A port must keep its request up while its own access is in flight.
  a_imem_hold : assert property (@(posedge clk) disable iff (!rst_n)
                                 (state_q == IBUSY) |-> imem_req);
  a_dmem_hold : assert property (@(posedge clk) disable iff (!rst_n)
                                 (state_q == DBUSY) |-> dmem_req);

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed and randomized bench for hart_mem_arbiter with a transaction-level reference model.
// Compile with HART_MEM_ARB_RR_EN defined to check the round-robin build.
module tb_hart_mem_arbiter;
  import hart_mem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int FW     = ADDR_W + WMASK_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               imem_req   = 1'b0;
  logic [ADDR_W-1:0]  imem_addr  = '0;
  logic [DATA_W-1:0]  imem_data;
  logic               imem_stall;
  logic               dmem_req   = 1'b0;
  logic [ADDR_W-1:0]  dmem_addr  = '0;
  logic [WMASK_W-1:0] dmem_wmask = '0;
  logic [DATA_W-1:0]  dmem_wdata = '0;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_stall;
  logic               mem_valid;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WMASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ready  = 1'b0;
  logic [DATA_W-1:0]  mem_rdata  = '0;
  arb_state_t         dbg_state;

  hart_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_stall (imem_stall),
    .dmem_req   (dmem_req),
    .dmem_addr  (dmem_addr),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_stall (dmem_stall),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int vectors     = 0;
  int miscompares = 0;

  // Expected memory transaction per outstanding request: {word addr, wmask, wdata}.
  logic [FW-1:0] i_exp_q[$];
  logic [FW-1:0] d_exp_q[$];

  bit            m_busy  = 1'b0;
  port_sel_t     m_owner = SEL_IMEM;
  port_sel_t     m_last  = SEL_IMEM;
  logic [FW-1:0] m_fields = '0;
  bit            i_cpl = 1'b0;
  bit            d_cpl = 1'b0;
  int            i_done = 0;
  int            d_done = 0;
  int            i_iss = 0;
  int            d_iss = 0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One model step per cycle, evaluated at the falling edge.
  task automatic model_check();
    logic exp_is;
    logic exp_ds;
    i_cpl = 1'b0;
    d_cpl = 1'b0;
    if (!m_busy) begin
      chk("idle_valid", FW'(mem_valid), FW'(0));
      chk("idle_state", FW'(dbg_state), FW'(IDLE));
      chk("idle_istall", FW'(imem_stall), FW'(imem_req));
      chk("idle_dstall", FW'(dmem_stall), FW'(dmem_req));
      if (imem_req || dmem_req) begin
        if (imem_req && dmem_req) begin
`ifdef HART_MEM_ARB_RR_EN
          m_owner = (m_last == SEL_DMEM) ? SEL_IMEM : SEL_DMEM;
`else
          m_owner = SEL_DMEM;
`endif
        end else begin
          m_owner = dmem_req ? SEL_DMEM : SEL_IMEM;
        end
        chk("model_queue_nonempty",
            FW'((m_owner == SEL_DMEM) ? d_exp_q.size() : i_exp_q.size()) != 0 ? FW'(1) : FW'(0),
            FW'(1));
        m_fields = (m_owner == SEL_DMEM) ? d_exp_q[0] : i_exp_q[0];
        m_busy   = 1'b1;
      end
    end else begin
      chk("busy_valid", FW'(mem_valid), FW'(1));
      chk("busy_state", FW'(dbg_state), FW'((m_owner == SEL_DMEM) ? DBUSY : IBUSY));
      chk("busy_fields", {mem_addr, mem_wmask, mem_wdata}, m_fields);
      exp_is = imem_req && !((m_owner == SEL_IMEM) && mem_ready);
      exp_ds = dmem_req && !((m_owner == SEL_DMEM) && mem_ready);
      chk("busy_istall", FW'(imem_stall), FW'(exp_is));
      chk("busy_dstall", FW'(dmem_stall), FW'(exp_ds));
      if (mem_ready) begin
        if (m_owner == SEL_IMEM) begin
          chk("imem_data", FW'(imem_data), FW'(mem_rdata));
          if (i_exp_q.size() != 0) void'(i_exp_q.pop_front());
          i_cpl = 1'b1;
          i_done++;
        end else begin
          if (dmem_wmask == '0) chk("dmem_rdata", FW'(dmem_rdata), FW'(mem_rdata));
          if (d_exp_q.size() != 0) void'(d_exp_q.pop_front());
          d_cpl = 1'b1;
          d_done++;
        end
        m_last = m_owner;
        m_busy = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic to_neg();
    #4;
    model_check();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    if (i_cpl) imem_req = 1'b0;
    if (d_cpl) dmem_req = 1'b0;
  endtask

  task automatic issue_i(input logic [ADDR_W-1:0] addr);
    imem_req  = 1'b1;
    imem_addr = addr;
    i_exp_q.push_back({addr[ADDR_W-1:2], 2'b00, {WMASK_W{1'b0}}, {DATA_W{1'b0}}});
    i_iss++;
  endtask

  task automatic issue_d(input logic [ADDR_W-1:0] addr, input logic [WMASK_W-1:0] wm,
                         input logic [DATA_W-1:0] wd);
    dmem_req   = 1'b1;
    dmem_addr  = addr;
    dmem_wmask = wm;
    dmem_wdata = wd;
    d_exp_q.push_back({addr[ADDR_W-1:2], 2'b00, wm, wd});
    d_iss++;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((imem_req || dmem_req || m_busy) && n < bound) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      to_neg();
      to_pos();
      n++;
    end
    mem_ready = 1'b0;
    chk("drain_done", FW'(imem_req || dmem_req || m_busy), FW'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int valid_cnt;
    int stall_cnt;
    int i_base;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", FW'(mem_valid), FW'(0));
    chk("rst_addr", FW'(mem_addr), FW'(0));
    chk("rst_wmask", FW'(mem_wmask), FW'(0));
    chk("rst_wdata", FW'(mem_wdata), FW'(0));
    chk("rst_state", FW'(dbg_state), FW'(IDLE));
    rst_n = 1'b1;

    // 1: single fetch, zero-wait memory, unaligned address
    issue_i(32'h0000_0103);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    to_neg();
    to_pos();
    to_neg();
    chk("t1_addr", FW'(mem_addr), FW'(32'h100));
    chk("t1_wmask", FW'(mem_wmask), FW'(0));
    chk("t1_istall", FW'(imem_stall), FW'(0));
    chk("t1_data", FW'(imem_data), FW'(32'h13));
    to_pos();
    mem_ready = 1'b0;
    to_neg();
    chk("t1_back_idle", FW'(dbg_state), FW'(IDLE));
    to_pos();

    // 2: store with three wait states
    issue_d(32'h0000_2000, 4'b0011, 32'hDEAD_BEEF);
    valid_cnt = 0;
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c == 4);
      mem_rdata = $urandom;
      to_neg();
      if (mem_valid) valid_cnt++;
      if (mem_valid && dmem_stall) stall_cnt++;
      to_pos();
    end
    mem_ready = 1'b0;
    chk("t2_valid_cycles", FW'(valid_cnt), FW'(4));
    chk("t2_stall_cycles", FW'(stall_cnt), FW'(3));

    // 3: simultaneous requests, zero-wait memory
    issue_i(32'h0000_0300);
    issue_d(32'h0000_0400, 4'b0000, 32'h0);
    stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      to_neg();
      if (imem_req && imem_stall) stall_cnt++;
      to_pos();
    end
    mem_ready = 1'b0;
`ifndef HART_MEM_ARB_RR_EN
    chk("t3_istall_cycles", FW'(stall_cnt), FW'(3));
`else
    chk("t3_istall_cycles", FW'(stall_cnt), FW'(1));
`endif

    // 4: both ports requesting back to back for 20 cycles
    i_base = i_done;
    issue_i(32'h0000_0500);
    issue_d(32'h0000_0600, 4'hF, $urandom);
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      to_neg();
      to_pos();
      if (!dmem_req) issue_d(32'h0000_0600 + 32'(c * 4), 4'hF, $urandom);
      if (!imem_req) issue_i(32'h0000_0500 + 32'(c * 4));
    end
`ifdef HART_MEM_ARB_RR_EN
    chk("t4_imem_completions", FW'(i_done - i_base), FW'(5));
`else
    chk("t4_imem_completions", FW'(i_done - i_base), FW'(0));
`endif
    drain(40);

    // 5: reset in the middle of a store
    issue_d(32'h0000_0700, 4'b1111, 32'h1234_5678);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      to_pos();
    end
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", FW'(mem_valid), FW'(0));
    chk("t5_rst_state", FW'(dbg_state), FW'(IDLE));
    dmem_req = 1'b0;
    d_exp_q.delete();
    i_exp_q.delete();
    d_iss  = d_done;
    m_busy = 1'b0;
    m_last = SEL_IMEM;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_base = i_done;
    issue_i(32'h0000_0804);
    drain(10);
    chk("t5_fetch_after_reset", FW'(i_done - i_base), FW'(1));

    // 6: random request and memory-wait traffic
    for (int c = 0; c < 400; c++) begin
      if (!imem_req && $urandom_range(0, 2) == 0) issue_i($urandom);
      if (!dmem_req && $urandom_range(0, 2) == 0)
        issue_d($urandom, 4'($urandom_range(0, 15)), $urandom);
      mem_ready = mem_valid && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      to_neg();
      to_pos();
    end
    drain(20);
    chk("t6_iq_empty", FW'(i_exp_q.size()), FW'(0));
    chk("t6_dq_empty", FW'(d_exp_q.size()), FW'(0));
    chk("t6_i_once", FW'(i_done), FW'(i_iss));
    chk("t6_d_once", FW'(d_done), FW'(d_iss));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
